// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Brief    : Instruction-fetch sequencer: PC, IF/ID register, branch/jump
//            redirect, load-use stall hold and start/halt run control.
//            Optional macro FETCH_PERF_CNT_EN builds saturating perf counters.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
    parameter int            AW       = 6,
    parameter int            DW       = 32,
    parameter logic [AW-1:0] RESET_PC = 'h01
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          halt_req,
    input  logic          stall,
    input  logic          br_taken,
    input  logic [AW-1:0] br_target,
    input  logic          jmp,
    input  logic [AW-1:0] jmp_target,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_inst,
    output logic [DW-1:0] if_id_inst,
    output logic [AW-1:0] if_id_pc,
    output logic          if_id_valid,
    output logic          flush_idex,
    output logic          fetch_busy,
    output logic [15:0]   cnt_fetch,
    output logic [15:0]   cnt_flush,
    output logic [15:0]   cnt_stall
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_HALT = 2'd2;

    logic [1:0]    r_state;
    logic [AW-1:0] r_pc;
    logic [DW-1:0] r_inst;
    logic [AW-1:0] r_ifpc;
    logic          r_valid;
    logic          w_run;

    assign w_run       = (r_state == c_RUN);
    assign rom_addr    = r_pc;
    assign flush_idex  = br_taken && w_run;
    assign fetch_busy  = w_run;
    assign if_id_inst  = r_inst;
    assign if_id_pc    = r_ifpc;
    assign if_id_valid = r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_pc    <= RESET_PC;
            r_inst  <= '0;
            r_ifpc  <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE, c_HALT: begin
                    // pc stays frozen so HALT resumes exactly where it stopped
                    r_inst  <= '0;
                    r_ifpc  <= '0;
                    r_valid <= 1'b0;
                    if (start) r_state <= c_RUN;
                end
                c_RUN: begin
                    if (halt_req) begin
                        r_state <= c_HALT;
                        r_inst  <= '0;
                        r_ifpc  <= '0;
                        r_valid <= 1'b0;
                    end else if (br_taken) begin
                        r_pc    <= br_target;
                        r_inst  <= '0;
                        r_ifpc  <= '0;
                        r_valid <= 1'b0;
                    end else if (stall) begin
                        // hold everything; a pending jmp is re-presented later
                        r_pc    <= r_pc;
                    end else if (jmp) begin
                        r_pc    <= jmp_target;
                        r_inst  <= '0;
                        r_ifpc  <= '0;
                        r_valid <= 1'b0;
                    end else begin
                        r_inst  <= rom_inst;
                        r_ifpc  <= r_pc;
                        r_valid <= 1'b1;
                        r_pc    <= r_pc + {{(AW-1){1'b0}}, 1'b1};
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic        w_ev_fetch;
    logic        w_ev_flush;
    logic        w_ev_stall;
    logic [15:0] r_cnt_fetch;
    logic [15:0] r_cnt_flush;
    logic [15:0] r_cnt_stall;

    // Events mirror the RUN priority chain so each edge counts at most once
    assign w_ev_fetch = w_run && !halt_req && !br_taken && !stall && !jmp;
    assign w_ev_flush = w_run && !halt_req && (br_taken || (!stall && jmp));
    assign w_ev_stall = w_run && !halt_req && !br_taken && stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_fetch <= '0;
            r_cnt_flush <= '0;
            r_cnt_stall <= '0;
        end else begin
            if (w_ev_fetch && (r_cnt_fetch != 16'hFFFF)) r_cnt_fetch <= r_cnt_fetch + 16'd1;
            if (w_ev_flush && (r_cnt_flush != 16'hFFFF)) r_cnt_flush <= r_cnt_flush + 16'd1;
            if (w_ev_stall && (r_cnt_stall != 16'hFFFF)) r_cnt_stall <= r_cnt_stall + 16'd1;
        end
    end

    assign cnt_fetch = r_cnt_fetch;
    assign cnt_flush = r_cnt_flush;
    assign cnt_stall = r_cnt_stall;
`else
    assign cnt_fetch = 16'd0;
    assign cnt_flush = 16'd0;
    assign cnt_stall = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Brief    : Scoreboard bench for fetch_ctrl; directed vectors push expected
//            outputs, a negedge monitor pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        halt_req;
    logic        stall;
    logic        br_taken;
    logic [5:0]  br_target;
    logic        jmp;
    logic [5:0]  jmp_target;
    logic [5:0]  rom_addr;
    logic [31:0] rom_inst;
    logic [31:0] if_id_inst;
    logic [5:0]  if_id_pc;
    logic        if_id_valid;
    logic        flush_idex;
    logic        fetch_busy;
    logic [15:0] cnt_fetch;
    logic [15:0] cnt_flush;
    logic [15:0] cnt_stall;

    fetch_ctrl #(.AW(6), .DW(32), .RESET_PC(6'h01)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .halt_req   (halt_req),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .jmp        (jmp),
        .jmp_target (jmp_target),
        .rom_addr   (rom_addr),
        .rom_inst   (rom_inst),
        .if_id_inst (if_id_inst),
        .if_id_pc   (if_id_pc),
        .if_id_valid(if_id_valid),
        .flush_idex (flush_idex),
        .fetch_busy (fetch_busy),
        .cnt_fetch  (cnt_fetch),
        .cnt_flush  (cnt_flush),
        .cnt_stall  (cnt_stall)
    );

    // Combinational ROM: each word carries its own address in the low bits
    assign rom_inst = {8'hA5, 18'h0, rom_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [5:0]  addr;
        logic        v;
        logic [5:0]  ipc;
        logic [31:0] inst;
        logic        flush;
        logic        busy;
        logic        ck;
        logic [15:0] cf;
        logic [15:0] cfl;
        logic [15:0] cs;
    } exp_t;

    exp_t        q[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    int          vec    = 0;
    logic        ck_next = 1'b0;
    logic [15:0] e_cf, e_cfl, e_cs;

`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, act, exp);
        end
    endtask

    // Apply one cycle of inputs and record what the DUT must present now
    task automatic cyc(input logic r, input logic s, input logic h, input logic st,
                       input logic b, input logic [5:0] bt, input logic j, input logic [5:0] jt,
                       input logic [5:0] ea, input logic ev, input logic [5:0] eip,
                       input logic ef, input logic eb);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; start = s; halt_req = h; stall = st;
        br_taken = b; br_target = bt; jmp = j; jmp_target = jt;
        vec++;
        e.idx = vec; e.addr = ea; e.v = ev; e.ipc = eip;
        e.inst = ev ? {8'hA5, 18'h0, eip} : 32'h0;
        e.flush = ef; e.busy = eb;
        e.ck = ck_next; e.cf = e_cf; e.cfl = e_cfl; e.cs = e_cs;
        ck_next = 1'b0;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rom_addr",    e.idx, {26'h0, rom_addr}, {26'h0, e.addr});
                chk("if_id_valid", e.idx, {31'h0, if_id_valid}, {31'h0, e.v});
                chk("if_id_pc",    e.idx, {26'h0, if_id_pc}, {26'h0, e.ipc});
                chk("if_id_inst",  e.idx, if_id_inst, e.inst);
                chk("flush_idex",  e.idx, {31'h0, flush_idex}, {31'h0, e.flush});
                chk("fetch_busy",  e.idx, {31'h0, fetch_busy}, {31'h0, e.busy});
                if (e.ck) begin
                    chk("cnt_fetch", e.idx, {16'h0, cnt_fetch}, {16'h0, e.cf});
                    chk("cnt_flush", e.idx, {16'h0, cnt_flush}, {16'h0, e.cfl});
                    chk("cnt_stall", e.idx, {16'h0, cnt_stall}, {16'h0, e.cs});
                end
            end
        end
    end

    initial begin : stim
        rst = 1'b1; start = 1'b0; halt_req = 1'b0; stall = 1'b0;
        br_taken = 1'b0; br_target = 6'h0; jmp = 1'b0; jmp_target = 6'h0;
        e_cf = 16'h0; e_cfl = 16'h0; e_cs = 16'h0;
        repeat (2) @(posedge clk);
        //   rst s h st b  bt    j  jt     addr  v  ipc  fl bsy
        cyc(0, 1, 0, 0, 0, 6'h00, 0, 6'h00, 6'h01, 0, 6'h00, 0, 0); // idle, start
        cyc(0, 0, 0, 0, 0, 6'h00, 0, 6'h00, 6'h01, 0, 6'h00, 0, 1);
        cyc(0, 0, 0, 0, 0, 6'h00, 0, 6'h00, 6'h02, 1, 6'h01, 0, 1);
        cyc(0, 0, 0, 0, 0, 6'h00, 0, 6'h00, 6'h03, 1, 6'h02, 0, 1);
        cyc(0, 0, 0, 0, 0, 6'h00, 0, 6'h00, 6'h04, 1, 6'h03, 0, 1);
        // stall with jmp at pc=05: everything holds, jmp ignored
        cyc(0, 0, 0, 1, 0, 6'h00, 1, 6'h20, 6'h05, 1, 6'h04, 0, 1);
        cyc(0, 0, 0, 1, 0, 6'h00, 1, 6'h20, 6'h05, 1, 6'h04, 0, 1);
        cyc(0, 0, 0, 1, 0, 6'h00, 1, 6'h20, 6'h05, 1, 6'h04, 0, 1);
        // branch beats stall and jmp
        cyc(0, 0, 0, 1, 1, 6'h12, 1, 6'h20, 6'h05, 1, 6'h04, 1, 1);
        cyc(0, 0, 0, 0, 0, 6'h00, 0, 6'h00, 6'h12, 0, 6'h00, 0, 1);
        // jump at pc=13 to 01
        cyc(0, 0, 0, 0, 0, 6'h00, 1, 6'h01, 6'h13, 1, 6'h12, 0, 1);
        cyc(0, 0, 0, 0, 0, 6'h00, 0, 6'h00, 6'h01, 0, 6'h00, 0, 1);
        cyc(0, 0, 0, 0, 0, 6'h00, 0, 6'h00, 6'h02, 1, 6'h01, 0, 1);
        cyc(0, 0, 0, 0, 0, 6'h00, 0, 6'h00, 6'h03, 1, 6'h02, 0, 1);
        cyc(0, 0, 0, 0, 0, 6'h00, 0, 6'h00, 6'h04, 1, 6'h03, 0, 1);
        cyc(0, 0, 0, 0, 0, 6'h00, 0, 6'h00, 6'h05, 1, 6'h04, 0, 1);
        cyc(0, 0, 0, 0, 0, 6'h00, 0, 6'h00, 6'h06, 1, 6'h05, 0, 1);
        // taken branch at pc=07 to 0A
        cyc(0, 0, 0, 0, 1, 6'h0A, 0, 6'h00, 6'h07, 1, 6'h06, 1, 1);
        cyc(0, 0, 0, 0, 0, 6'h00, 0, 6'h00, 6'h0A, 0, 6'h00, 0, 1);
        cyc(0, 0, 0, 0, 0, 6'h00, 1, 6'h09, 6'h0B, 1, 6'h0A, 0, 1);
        // halt at pc=09, then five HALT cycles ignoring hazards
        cyc(0, 0, 1, 0, 0, 6'h00, 0, 6'h00, 6'h09, 0, 6'h00, 0, 1);
        cyc(0, 0, 1, 0, 0, 6'h00, 0, 6'h00, 6'h09, 0, 6'h00, 0, 0);
        cyc(0, 0, 0, 0, 1, 6'h30, 0, 6'h00, 6'h09, 0, 6'h00, 0, 0);
        cyc(0, 0, 0, 1, 0, 6'h00, 0, 6'h00, 6'h09, 0, 6'h00, 0, 0);
        cyc(0, 0, 0, 0, 0, 6'h00, 1, 6'h20, 6'h09, 0, 6'h00, 0, 0);
        cyc(0, 0, 0, 0, 0, 6'h00, 0, 6'h00, 6'h09, 0, 6'h00, 0, 0);
        cyc(0, 1, 0, 0, 0, 6'h00, 0, 6'h00, 6'h09, 0, 6'h00, 0, 0); // resume
        cyc(0, 0, 0, 0, 0, 6'h00, 0, 6'h00, 6'h09, 0, 6'h00, 0, 1);
        cyc(0, 1, 0, 0, 0, 6'h00, 0, 6'h00, 6'h0A, 1, 6'h09, 0, 1); // start in RUN ignored
        // wrap 3E -> 3F -> 00
        cyc(0, 0, 0, 0, 0, 6'h00, 1, 6'h3E, 6'h0B, 1, 6'h0A, 0, 1);
        cyc(0, 0, 0, 0, 0, 6'h00, 0, 6'h00, 6'h3E, 0, 6'h00, 0, 1);
        cyc(0, 0, 0, 0, 0, 6'h00, 0, 6'h00, 6'h3F, 1, 6'h3E, 0, 1);
        cyc(0, 0, 1, 0, 0, 6'h00, 0, 6'h00, 6'h00, 1, 6'h3F, 0, 1);
        // counters before reset: 16 fetches, 5 redirects, 3 stall cycles
        ck_next = 1'b1;
        e_cf  = PERF ? 16'd16 : 16'd0;
        e_cfl = PERF ? 16'd5  : 16'd0;
        e_cs  = PERF ? 16'd3  : 16'd0;
        cyc(1, 0, 0, 0, 0, 6'h00, 0, 6'h00, 6'h00, 0, 6'h00, 0, 0); // rst during HALT
        ck_next = 1'b1;
        e_cf = 16'd0; e_cfl = 16'd0; e_cs = 16'd0;
        cyc(0, 0, 0, 0, 0, 6'h00, 0, 6'h00, 6'h01, 0, 6'h00, 0, 0);
        cyc(0, 0, 0, 0, 0, 6'h00, 1, 6'h20, 6'h01, 0, 6'h00, 0, 0);
        @(negedge clk);
        #1;
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the pipelined CPU.
- Owns the PC and drives the 6-bit word address of the combinational instruction ROM.
- Registers the fetched word into the IF/ID pipeline register.
- Resolves control hazards: branch/jump redirect with flush, load-use stall hold, and start/halt run control.

Parameters:
- AW, 6: PC / ROM address width in words.
- DW, 32: instruction width.
- RESET_PC, 6'h01: first fetch address after start. Word 0 is left empty.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; IDLE/HALT -> RUN.
- halt_req  in  1  halt from WB stage.
- stall  in  1  hazard unit hold (load-use).
- br_taken  in  1  EX-stage branch resolved taken.
- br_target  in  AW  branch target word address.
- jmp  in  1  ID-stage unconditional jump.
- jmp_target  in  AW  jump target word address.
- rom_addr  out  AW  ROM address; combinational, equals pc.
- rom_inst  in  DW  ROM data, valid in the same cycle.
- if_id_inst  out  DW  registered instruction.
- if_id_pc  out  AW  PC of if_id_inst.
- if_id_valid  out  1  0 = bubble.
- flush_idex  out  1  combinational; br_taken && state==RUN.
- fetch_busy  out  1  state==RUN.
- cnt_fetch, cnt_flush, cnt_stall  out  16 each  performance counters (see Optional Feature).

Behaviour:
- Reset (rst=1 at a clk edge, any state, mid-redirect included):
  - pc<=RESET_PC; state<=IDLE.
  - if_id_inst<=0, if_id_pc<=0, if_id_valid<=0.
  - Counters<=0.
- FSM states: IDLE, RUN, HALT.
  - IDLE: pc held; IF/ID loaded with bubble each cycle. start -> RUN. Other inputs ignored.
  - RUN, per-edge priority, highest first:
    1. halt_req: state<=HALT; IF/ID<=bubble; pc held.
    2. br_taken: pc<=br_target; IF/ID<=bubble. flush_idex=1 in the same cycle. Overrides stall and jmp.
    3. stall: pc and IF/ID hold their values. A jmp asserted during stall is ignored; it is re-presented once the stalled ID instruction releases.
    4. jmp: pc<=jmp_target; IF/ID<=bubble (one slot lost).
    5. Normal: if_id_inst<=rom_inst, if_id_pc<=pc, if_id_valid<=1, pc<=pc+1.
  - HALT: pc frozen; bubbles only. start -> RUN, resuming at the frozen pc. halt_req while in HALT has no effect.
- Bubble definition: inst=0, pc=0, valid=0.
- Latency: ROM is combinational, so a word is visible at the IF/ID output 1 cycle after pc addresses it.
  - Taken-branch penalty: 2 slots (IF/ID bubble + ID/EX flush).
  - Jump penalty: 1 slot.
- Arithmetic: pc+1 is modulo 2^AW; 6'h3F wraps to 6'h00 with no flag. Targets are used verbatim; no range check.
- start asserted while in RUN: ignored.
- flush_idex is 0 outside RUN.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: three 16-bit counters, saturating at 16'hFFFF, cleared only by rst.
  - cnt_fetch increments on each normal fetch.
  - cnt_flush increments on each br_taken or jmp redirect taken in RUN.
  - cnt_stall increments on each RUN cycle where stall holds.
- Undefined: the ports remain but are tied to 0, and no counter flops are built.

Test Plan:
- rst 2 cycles, start pulse, no hazards for 4 cycles -> rom_addr sequence 01,02,03,04,05; if_id_pc 01,02,03,04 with valid=1 from the 2nd edge after start.
- Branch: in RUN at pc=07, br_taken=1, br_target=0A for 1 cycle -> flush_idex=1 that cycle; next cycle if_id_valid=0 and rom_addr=0A; following cycle if_id_pc=0A.
- stall=1 for 3 cycles at pc=05 with jmp=1 -> pc stays 05 and if_id unchanged; jmp ignored. Same cycle as br_taken (target 12) -> br wins, pc=12.
- Jump: jmp=1, jmp_target=01 at pc=13 -> one bubble, then fetch resumes at 01. Run pc to 3F with no hazards -> next rom_addr=00.
- halt_req at pc=09 -> HALT, bubbles, pc=09 held 5 cycles. start -> resumes fetching 09. rst during HALT -> IDLE, pc=01.
- With FETCH_PERF_CNT_EN: run the sequence above -> counters match the counted events exactly. Without the macro -> all counters read 0.
